reg_file_2r1w: RTL and testbench
================================

REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 Parameter WIDTH, default 16: bits per register.
REQ-002 Parameter DEPTH, default 8: number of registers, power of two, at least 2.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 reads as zero and ignores writes.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port wen, input, 1 bit: write enable.
REQ-007 Port waddr, input, log2(DEPTH) bits: write address.
REQ-008 Port wdata, input, WIDTH bits: write data.
REQ-009 Ports ren1 and ren2, input, 1 bit each: read enables for ports 1 and 2.
REQ-010 Ports raddr1 and raddr2, input, log2(DEPTH) bits each: read addresses.
REQ-011 Ports rdata1 and rdata2, output, WIDTH bits each: registered read data.
REQ-012 Ports rvalid1 and rvalid2, output, 1 bit each: read data valid, one per port.
REQ-013 Port written, output, DEPTH bits: per-entry "written since reset" flags.

Function
REQ-014 Storage: DEPTH x WIDTH flip-flops; an entry loads wdata on the edge where wen=1 and waddr selects it.
REQ-015 Reads: synchronous with 1-cycle latency; ren1=1 at edge N sets rdata1 = entry[raddr1] as of before edge N, and sets rvalid1=1 after edge N.
REQ-016 Read idle: when a read enable is 0 at an edge, the port's rdata holds its previous value and its rvalid goes to 0.
REQ-017 Ports 1 and 2 are fully independent; both may read the same address in the same cycle.
REQ-018 Written flags: the entry's written flag is set on the same edge as the write; it is never cleared except by reset.
REQ-019 Zero register (ZERO_REG=1): writes to address 0 are dropped and written[0] stays 0; reads of address 0 return all-zero with normal rvalid timing.
REQ-020 Read data is driven through a multiplexer only; no tri-state drivers inside the block.
REQ-021 Read/write collision (same address, same cycle) without bypass: the read returns the old entry value, and the new value is visible from the next read onward.

Reset
REQ-022 When rst=1 at an edge: every entry clears to 0, every written flag clears to 0, rdata1 and rdata2 clear to 0, and rvalid1 and rvalid2 clear to 0.
REQ-023 rst takes priority over wen and ren in the same cycle; that write is lost and that read produces rvalid=0.
REQ-024 A read issued in the cycle before reset completes normally; the reset edge then clears its output.

Configuration
REQ-025 Macro REG_FILE_BYPASS_EN.
REQ-026 With the macro defined: on a read/write collision to a non-zero-register address, rdata takes wdata, so the new value is read in the same cycle.
REQ-027 Without the macro: collision behaviour follows REQ-021.
REQ-028 Reads of address 0 with ZERO_REG=1 always return zero, regardless of the macro.

Structure
REQ-029 Shared package reg_file_pkg holds the WIDTH and DEPTH default constants and an address-width function (clog2).
REQ-030 Sub-module reg_row: a WIDTH-bit register with write enable and synchronous reset, instantiated DEPTH times (or DEPTH-1 times when ZERO_REG=1).
REQ-031 Read multiplexing and bypass logic live in the top module.

Verification
REQ-032 Reset test: hold rst=1 for 2 cycles, then issue ren1 to address 5 -> rdata1=0x0000, rvalid1=1 one cycle later, written=0x00.
REQ-033 Write/read test: write 0xBEEF to address 3; next cycle read address 3 on both ports -> rdata1=rdata2=0xBEEF, and written[3]=1.
REQ-034 Collision test: address 6 holds 0x1111; in one cycle write 0x2222 to address 6 and read address 6 on port 1 -> rdata1=0x1111 without the macro, 0x2222 with it; the next read returns 0x2222 in both builds.
REQ-035 Zero-register test: write 0xFFFF to address 0, then read address 0 -> rdata=0x0000 and written[0]=0.
REQ-036 Hold test: read 0xBEEF, then drop ren1 for 3 cycles -> rdata1 stays 0xBEEF and rvalid1=0.
REQ-037 Reset-priority test: assert rst together with a write of 0xAAAA to address 2 -> entry 2 = 0 and written[2]=0 afterwards.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared default sizes and address-width helper for the register file
package reg_file_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/reg_file_2r1w_reg_row.sv
// reg_row: one WIDTH-bit register entry with write enable and synchronous reset
module reg_row
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] row_d, row_q;
  always_comb row_d = we ? d : row_q;
  always_ff @(posedge clk) row_q <= rst ? '0 : row_d;
  assign q = row_q;
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 2-read/1-write register file, registered reads; REG_FILE_BYPASS_EN forwards colliding writes
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int AW = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren1,
  input  logic [AW-1:0]    raddr1,
  input  logic             ren2,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  output logic             rvalid1,
  output logic             rvalid2,
  output logic [DEPTH-1:0] written
);
  logic [WIDTH-1:0] entries [DEPTH];
  logic [WIDTH-1:0] rd1, rd2, rdata1_d, rdata1_q, rdata2_d, rdata2_q;
  logic             rvalid1_d, rvalid1_q, rvalid2_d, rvalid2_q;
  logic [DEPTH-1:0] written_d, written_q, keep;
  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign entries[i] = '0;
    end else begin : g_reg
      reg_row #(.WIDTH(WIDTH)) u_row (
        .clk(clk), .rst(rst), .we(wen && waddr == AW'(i)), .d(wdata), .q(entries[i])
      );
    end
  end
  assign keep = ZERO_REG != 0 ? ~DEPTH'(1) : '1;
  always_comb begin
`ifdef REG_FILE_BYPASS_EN
    rd1 = (wen && waddr == raddr1 && keep[raddr1]) ? wdata : entries[raddr1];
    rd2 = (wen && waddr == raddr2 && keep[raddr2]) ? wdata : entries[raddr2];
`else
    rd1 = entries[raddr1];
    rd2 = entries[raddr2];
`endif
    rdata1_d = ren1 ? rd1 : rdata1_q;
    rdata2_d = ren2 ? rd2 : rdata2_q;
    rvalid1_d = ren1;
    rvalid2_d = ren2;
    written_d = written_q | (wen ? (DEPTH'(1) << waddr) & keep : '0);
  end
  always_ff @(posedge clk) begin
    rdata1_q  <= rst ? '0 : rdata1_d;
    rdata2_q  <= rst ? '0 : rdata2_d;
    rvalid1_q <= rst ? 1'b0 : rvalid1_d;
    rvalid2_q <= rst ? 1'b0 : rvalid2_d;
    written_q <= rst ? '0 : written_d;
  end
  assign rdata1  = rdata1_q;
  assign rdata2  = rdata2_q;
  assign rvalid1 = rvalid1_q;
  assign rvalid2 = rvalid2_q;
  assign written = written_q;
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: scoreboard bench; expected read data queued at issue, checked when rvalid appears
module tb_reg_file_2r1w;
  logic        clk = 0, rst = 1, wen = 0, ren1 = 0, ren2 = 0;
  logic [2:0]  waddr = 0, raddr1 = 0, raddr2 = 0;
  logic [15:0] wdata = 0, rdata1, rdata2;
  logic        rvalid1, rvalid2;
  logic [7:0]  written;
  int tests = 0, fails = 0;
  logic [15:0] q1[$], q2[$];
`ifdef REG_FILE_BYPASS_EN
  localparam logic [15:0] COLL = 16'h2222;
`else
  localparam logic [15:0] COLL = 16'h1111;
`endif

  reg_file_2r1w dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren1(ren1), .raddr1(raddr1), .ren2(ren2), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .rvalid1(rvalid1), .rvalid2(rvalid2), .written(written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops one expected value per valid read beat
  always @(posedge clk) begin
    #1;
    if (rvalid1) begin
      if (q1.size() == 0) chk("rd1_unexpected", 32'(rvalid1), 32'd0);
      else chk("rdata1", 32'(rdata1), 32'(q1.pop_front()));
    end
    if (rvalid2) begin
      if (q2.size() == 0) chk("rd2_unexpected", 32'(rvalid2), 32'd0);
      else chk("rdata2", 32'(rdata2), 32'(q2.pop_front()));
    end
  end

  task automatic issue(input bit r, input bit w, input logic [2:0] wa, input logic [15:0] wd,
                       input bit e1, input logic [2:0] a1, input logic [15:0] x1,
                       input bit e2, input logic [2:0] a2, input logic [15:0] x2);
    @(negedge clk);
    rst = r; wen = w; waddr = wa; wdata = wd;
    ren1 = e1; raddr1 = a1; ren2 = e2; raddr2 = a2;
    if (e1 && !r) q1.push_back(x1);
    if (e2 && !r) q2.push_back(x2);
  endtask

  task automatic idle();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(); settle();
    chk("reset_rdata1", 32'(rdata1), 0);
    chk("reset_rvalid1", 32'(rvalid1), 0);
    chk("reset_written", 32'(written), 0);
    issue(0, 0, 0, 0, 1, 5, 16'h0000, 0, 0, 0);
    issue(0, 1, 3, 16'hBEEF, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 1, 3, 16'hBEEF, 1, 3, 16'hBEEF);
    idle(); settle();
    chk("written_3", 32'(written), 32'h08);
    for (int k = 0; k < 3; k++) begin
      idle(); settle();
      chk("hold_rdata1", 32'(rdata1), 32'hBEEF);
      chk("hold_rvalid1", 32'(rvalid1), 0);
    end
    issue(0, 1, 6, 16'h1111, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 6, 16'h2222, 1, 6, COLL, 0, 0, 0);
    issue(0, 0, 0, 0, 1, 6, 16'h2222, 1, 6, 16'h2222);
    issue(0, 1, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 0, 16'h5555, 1, 0, 16'h0000, 1, 0, 16'h0000);
    issue(0, 0, 0, 0, 1, 0, 16'h0000, 1, 6, 16'h2222);
    idle(); settle();
    chk("written_zero", 32'(written), 32'h48);
    issue(0, 0, 0, 0, 1, 3, 16'hBEEF, 0, 0, 0);
    issue(1, 1, 2, 16'hAAAA, 1, 3, 0, 1, 2, 0);
    settle();
    chk("rst_rdata1", 32'(rdata1), 0);
    chk("rst_rvalid2", 32'(rvalid2), 0);
    chk("rst_written", 32'(written), 0);
    issue(0, 0, 0, 0, 1, 2, 16'h0000, 1, 3, 16'h0000);
    issue(0, 1, 7, 16'h1234, 1, 6, 16'h0000, 0, 0, 0);
    issue(0, 0, 0, 0, 1, 3, 16'h0000, 1, 7, 16'h1234);
    idle(); settle();
    chk("written_7", 32'(written), 32'h80);
    repeat (3) begin idle(); settle(); end
    chk("q1_drained", 32'(q1.size()), 0);
    chk("q2_drained", 32'(q2.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
